sqrt_fixed_point_stream: RTL and testbench

//  Unsigned fixed-point square root with valid/ready streaming handshakes and a sideband tag.

---
 rtl/sqrt_fixed_point_stream.sv | 137 +++++++++++++
 tb/tb_sqrt_fixed_point_stream.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_fixed_point_stream.sv
// Unsigned fixed-point square root, digit-by-digit, one root bit per clock.
// Streams radicand+tag in and root/remainder/tag out over valid/ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_rad, in_tag sampled on accept
//   out_valid/out_ready   output handshake; out_root, out_rem, out_tag held
//                         stable until the result is taken
// Parameters: WIDTH (radicand/root width), FBITS (fractional bits),
//   TAG_W (sideband tag width). WIDTH+FBITS must be even.
// Build option: define SQRT_ROUND_EN for round-half-up of out_root
//   (one extra iteration); out_rem stays the truncated-root remainder.

module sqrt_fixed_point_stream #(
    parameter int WIDTH = 16,
    parameter int FBITS = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rad,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_root,
    output logic [WIDTH:0]   out_rem,
    output logic [TAG_W-1:0] out_tag
);

    localparam int XW   = WIDTH + FBITS;
    localparam int BASE = XW / 2;
`ifdef SQRT_ROUND_EN
    localparam int ITER = BASE + 1;
    localparam int RW   = WIDTH + 1;
`else
    localparam int ITER = BASE;
    localparam int RW   = WIDTH;
`endif
    localparam int AW = RW + 2;
    localparam int CW = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [XW-1:0]    x;
    logic [AW-1:0]    acc;
    logic [RW-1:0]    root;
    logic [CW-1:0]    cnt;
    logic [TAG_W-1:0] tag_q;

    logic [AW-1:0]    acc_sh;
    logic [AW:0]      trial;
    logic [AW-1:0]    acc_nx;
    logic [RW-1:0]    root_nx;
    logic [WIDTH-1:0] root_fin;
    logic [WIDTH:0]   rem_fin;

    // Bring down the next two radicand bits and try subtracting 4*root+1.
    assign acc_sh  = {acc[AW-3:0], x[XW-1:XW-2]};
    assign trial   = {1'b0, acc_sh} - {1'b0, root, 2'b01};
    assign acc_nx  = trial[AW] ? acc_sh : trial[AW-1:0];
    assign root_nx = {root[RW-2:0], ~trial[AW]};

    // The remainder never needs the top two accumulator bits.
    logic unused_ok;
    assign unused_ok = ^acc[AW-1:AW-2];

`ifdef SQRT_ROUND_EN
    logic [WIDTH-1:0] trunc;
    logic             guard;
    assign trunc = root_nx[RW-1:1];
    assign guard = root_nx[0];
    assign root_fin = (guard && !(&trunc))
                    ? trunc + {{(WIDTH-1){1'b0}}, 1'b1}
                    : trunc;
    // Remainder before the guard iteration belongs to the truncated root.
    assign rem_fin = acc[WIDTH:0];
`else
    assign root_fin = root_nx;
    assign rem_fin  = acc_nx[WIDTH:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x         <= '0;
            acc       <= '0;
            root      <= '0;
            cnt       <= '0;
            tag_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_root  <= '0;
            out_rem   <= '0;
            out_tag   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x        <= {in_rad, {FBITS{1'b0}}};
                        tag_q    <= in_tag;
                        acc      <= '0;
                        root     <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    x    <= {x[XW-3:0], 2'b00};
                    acc  <= acc_nx;
                    root <= root_nx;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out_root  <= root_fin;
                        out_rem   <= rem_fin;
                        out_tag   <= tag_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_fixed_point_stream.sv
// Self-checking bench for sqrt_fixed_point_stream.
// Vector table plus scoreboard queue; hand sequences for timing corners.

module tb_sqrt_fixed_point_stream;

    localparam int WIDTH = 16;
    localparam int FBITS = 8;
    localparam int TAG_W = 4;
`ifdef SQRT_ROUND_EN
    localparam int LAT = 14;
`else
    localparam int LAT = 13;
`endif
    // LAT counts edges from the accepting edge (inclusive) to out_valid.

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_rad = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_root;
    logic [WIDTH:0]   out_rem;
    logic [TAG_W-1:0] out_tag;

    sqrt_fixed_point_stream #(
        .WIDTH(WIDTH), .FBITS(FBITS), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rad(in_rad), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_root(out_root), .out_rem(out_rem), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] rad;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] root;
        logic [WIDTH:0]   rem;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] root;
        logic [WIDTH:0]   rem;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input longint act,
                         input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic longint isqrt(input longint v);
        longint lo = 0;
        longint hi = 64'd1 << 24;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic exp_t model(input logic [WIDTH-1:0] rad,
                                   input logic [TAG_W-1:0] tag);
        exp_t   e;
        longint v = longint'(rad) << FBITS;
        longint t = isqrt(v);
        longint r = t;
`ifdef SQRT_ROUND_EN
        r = t + (isqrt(4 * v) & 1);
        if (r > (64'd1 << WIDTH) - 1) r = (64'd1 << WIDTH) - 1;
`endif
        e.root = WIDTH'(r);
        e.rem  = (WIDTH+1)'(v - t * t);
        e.tag  = tag;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
    endtask

    task automatic pop_cmp(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({name, "_root"}, out_root, e.root);
            check({name, "_rem"}, out_rem, e.rem);
            check({name, "_tag"}, out_tag, e.tag);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] rad,
                          input logic [TAG_W-1:0] tag,
                          input exp_t e, input int hold, input bit poke);
        int lat;
        logic [WIDTH-1:0] r0;
        logic [WIDTH:0]   m0;
        logic [TAG_W-1:0] g0;
        bit stable;
        wait_ready();
        in_valid = 1'b1;
        in_rad   = rad;
        in_tag   = tag;
        sb.push_back(e);
        tick();
        lat = 1;
        in_rad = WIDTH'($urandom);
        in_tag = TAG_W'($urandom);
        while (!out_valid && lat < 100) begin
            in_valid = poke && (lat == 4);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, LAT);
        if (hold > 0) begin
            r0 = out_root;
            m0 = out_rem;
            g0 = out_tag;
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                tick();
                if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                    out_root !== r0 || out_rem !== m0 || out_tag !== g0)
                    stable = 1'b0;
            end
            in_valid = 1'b0;
            check("backpressure_stable", stable, 1);
        end
        pop_cmp("result");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
    endtask

    vec_t vecs[10];

    initial begin
        int nres;
        int acc1;
        int acc2;
        int nacc;
        bit quiet;
        bit go;

        vecs[0] = '{rad: 16'd59536, tag: 4'd3, root: 16'd3904, rem: 17'd0};
        vecs[1] = '{rad: 16'd64, tag: 4'd5, root: 16'd128, rem: 17'd0};
        vecs[2] = '{rad: 16'd512, tag: 4'd6, root: 16'd362, rem: 17'd28};
`ifdef SQRT_ROUND_EN
        vecs[3] = '{rad: 16'd65535, tag: 4'd9, root: 16'd4096, rem: 17'd7935};
`else
        vecs[3] = '{rad: 16'd65535, tag: 4'd9, root: 16'd4095, rem: 17'd7935};
`endif
        vecs[4] = '{rad: 16'd0, tag: 4'd0, root: 16'd0, rem: 17'd0};
        vecs[5].rad = 16'd1;     vecs[5].tag = 4'd7;
        vecs[6].rad = 16'd3;     vecs[6].tag = 4'd8;
        vecs[7].rad = 16'd255;   vecs[7].tag = 4'd10;
        vecs[8].rad = 16'd40000; vecs[8].tag = 4'd11;
        vecs[9].rad = WIDTH'($urandom); vecs[9].tag = 4'd12;
        for (int i = 5; i < 10; i++) begin
            exp_t e;
            e = model(vecs[i].rad, vecs[i].tag);
            vecs[i].root = e.root;
            vecs[i].rem  = e.rem;
        end

        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_root", out_root, 0);
        check("rst_out_rem", out_rem, 0);
        check("rst_out_tag", out_tag, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e = '{root: vecs[i].root, rem: vecs[i].rem, tag: vecs[i].tag};
            run_op(vecs[i].rad, vecs[i].tag, e,
                   (i == 0) ? 20 : 0, vecs[i].rad == 0);
            if (vecs[i].rad == 0) begin
                quiet = 1'b1;
                for (int k = 0; k < LAT + 4; k++) begin
                    tick();
                    if (out_valid) quiet = 1'b0;
                end
                check("no_extra_result", quiet, 1);
            end
        end

        // Back-to-back with out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_rad    = 16'd64;
        in_tag    = 4'd1;
        nres = 0;
        nacc = 0;
        acc1 = 0;
        acc2 = 0;
        for (int cyc = 0; cyc < 80 && nres < 2; cyc++) begin
            go = in_valid && in_ready;
            if (go) sb.push_back(model(in_rad, in_tag));
            if (out_valid) begin
                pop_cmp("b2b");
                nres++;
            end
            tick();
            if (go) begin
                nacc++;
                if (nacc == 1) begin
                    acc1 = cyc;
                    in_rad = 16'd512;
                    in_tag = 4'd2;
                end else begin
                    acc2 = cyc;
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", nres, 2);
        check("b2b_gap", acc2 - acc1, LAT + 1);
        tick();

        // Reset during CALC discards the operation.
        wait_ready();
        in_valid = 1'b1;
        in_rad   = 16'd59536;
        in_tag   = 4'd4;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_root", out_root, 0);
        check("midrst_out_tag", out_tag, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_op(16'd512, 4'd13, model(16'd512, 4'd13), 0, 1'b0);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
